// File: rtl/riscvsinglecycle_branch_predictor.sv
// -----------------------------------------------------------------------------
// riscvsinglecycle_branch_predictor
//
// Purpose:
//   Branch predictor for a single-cycle RISC-V core. It holds a table of
//   2-bit saturating counters indexed by PC[log2(ENTRIES)+1:2]. The lookup
//   path is purely combinational, so a prediction is available in the same
//   cycle as the fetch. The table is trained by resolved conditional branches
//   at retirement. The block also keeps a registered mispredict flag and two
//   saturating 32-bit statistics counters.
//
// Optional feature:
//   RISCVSINGLECYCLE_BP_GSHARE_EN - when defined, a GHR_BITS-wide global
//   history register is XORed (zero-extended) into both the lookup index and
//   the update index, which gives gshare indexing.
//
// Parameters:
//   ENTRIES   number of 2-bit counters (power of two, 4..1024)
//   GHR_BITS  global history width (<= log2(ENTRIES)); gshare build only
//
// Ports:
//   clk               in   sole clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   pred_pc[31:0]     in   PC of the instruction being fetched
//   pred_taken        out  taken prediction for pred_pc (combinational)
//   upd_valid         in   a resolved conditional branch retires this cycle
//   upd_pc[31:0]      in   PC of the resolved branch
//   upd_taken         in   actual branch outcome
//   upd_pred          in   prediction that was issued for this branch
//   mispredict        out  registered mispredict flag
//   branch_count      out  number of resolved branches (saturating)
//   mispredict_count  out  number of mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module riscvsinglecycle_branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int GHR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       r_table [ENTRIES];
  logic             r_mispredict;
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;

  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [1:0]       w_cnt_cur;
  logic [1:0]       w_cnt_next;
  logic             w_mispredict;
  logic [31:0]      w_branch_next;
  logic [31:0]      w_mispredict_next;

`ifdef RISCVSINGLECYCLE_BP_GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;
  logic [IDX_W-1:0]    w_ghr_ext;

  assign w_ghr_ext  = IDX_W'(r_ghr);
  // Lookup and update share the same pre-shift history, as in a single-cycle core.
  assign w_pred_idx = pred_pc[IDX_W+1:2] ^ w_ghr_ext;
  assign w_upd_idx  = upd_pc[IDX_W+1:2] ^ w_ghr_ext;

  // Global history: shift in the resolved outcome on every retiring branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_ghr <= (r_ghr << 1) | GHR_BITS'(upd_taken);
    end else begin
      r_ghr <= r_ghr;
    end
  end
`else
  // History width only matters for the gshare build.
  localparam int UNUSED_GHR_BITS = GHR_BITS;

  assign w_pred_idx = pred_pc[IDX_W+1:2];
  assign w_upd_idx  = upd_pc[IDX_W+1:2];
`endif

  // PC bits outside the index field never affect the table.
  logic w_unused_pc;
  assign w_unused_pc = &{1'b0, pred_pc[31:IDX_W+2], pred_pc[1:0],
                         upd_pc[31:IDX_W+2], upd_pc[1:0]};

  // No bypass: the prediction always reflects the stored (pre-update) counter.
  assign pred_taken = r_table[w_pred_idx][1];
  assign w_cnt_cur  = r_table[w_upd_idx];
  assign w_mispredict = upd_valid & (upd_taken ^ upd_pred);

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (upd_taken) begin
      if (w_cnt_cur != 2'd3) begin
        w_cnt_next = w_cnt_cur + 2'd1;
      end else begin
        w_cnt_next = w_cnt_cur;
      end
    end else begin
      if (w_cnt_cur != 2'd0) begin
        w_cnt_next = w_cnt_cur - 2'd1;
      end else begin
        w_cnt_next = w_cnt_cur;
      end
    end
  end

  // Next values of the statistics counters; both stick at all-ones.
  always_comb begin
    w_branch_next     = r_branch_count;
    w_mispredict_next = r_mispredict_count;
    if (upd_valid && (r_branch_count != 32'hFFFF_FFFF)) begin
      w_branch_next = r_branch_count + 32'd1;
    end else begin
      w_branch_next = r_branch_count;
    end
    if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
      w_mispredict_next = r_mispredict_count + 32'd1;
    end else begin
      w_mispredict_next = r_mispredict_count;
    end
  end

  // Counter table: every entry resets to weak-not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= 2'd1;
      end
    end else if (upd_valid) begin
      r_table[w_upd_idx] <= w_cnt_next;
    end else begin
      r_table[w_upd_idx] <= r_table[w_upd_idx];
    end
  end

  // Mispredict flag and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict       <= 1'b0;
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      r_mispredict       <= w_mispredict;
      r_branch_count     <= w_branch_next;
      r_mispredict_count <= w_mispredict_next;
    end
  end

  assign mispredict       = r_mispredict;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_riscvsinglecycle_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_riscvsinglecycle_branch_predictor
//
// Self-checking bench for riscvsinglecycle_branch_predictor (ENTRIES=64,
// GHR_BITS=6). It uses a behavioural model that keeps one integer per table
// entry and applies the saturating counter rules directly. The bench honours
// RISCVSINGLECYCLE_BP_GSHARE_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_riscvsinglecycle_branch_predictor;

  localparam int ENTRIES  = 64;
  localparam int GHR_BITS = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     mdl_tab [ENTRIES];
  longint mdl_br;
  longint mdl_mis;
  logic   mdl_mp;
  int     mdl_ghr;

  always #5 clk = ~clk;

  riscvsinglecycle_branch_predictor #(.ENTRIES(ENTRIES), .GHR_BITS(GHR_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .mispredict(mispredict), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  function automatic int midx(input logic [31:0] pc);
    int b;
    b = int'((pc >> 2) & 32'(ENTRIES - 1));
`ifdef RISCVSINGLECYCLE_BP_GSHARE_EN
    b = b ^ mdl_ghr;
`endif
    return b;
  endfunction

  function automatic logic mpred(input logic [31:0] pc);
    return (mdl_tab[midx(pc)] >= 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < ENTRIES; i++) mdl_tab[i] = 1;
    mdl_br = 0; mdl_mis = 0; mdl_mp = 1'b0; mdl_ghr = 0;
  endtask

  task automatic mdl_update(input logic v, input logic [31:0] pc, input logic t, input logic p);
    int i;
    mdl_mp = v && (t != p);
    if (v) begin
      i = midx(pc);
      if (t && mdl_tab[i] < 3) mdl_tab[i] = mdl_tab[i] + 1;
      if (!t && mdl_tab[i] > 0) mdl_tab[i] = mdl_tab[i] - 1;
      if (mdl_br < 64'hFFFF_FFFF) mdl_br = mdl_br + 1;
      if (mdl_mp && mdl_mis < 64'hFFFF_FFFF) mdl_mis = mdl_mis + 1;
      mdl_ghr = ((mdl_ghr << 1) | int'(t)) % (1 << GHR_BITS);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pred_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_pred = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Presents one cycle of stimulus. The prediction is checked before the edge
  // and the registered outputs are checked after it. The task is entered and
  // left just after a rising edge.
  task automatic apply(input logic v, input logic [31:0] upc, input logic t,
                       input logic p, input logic [31:0] lpc);
    logic exp_p;
    upd_valid = v; upd_pc = upc; upd_taken = t; upd_pred = p; pred_pc = lpc;
    #1;
    exp_p = mpred(lpc);
    checks++;
    if (pred_taken !== exp_p) begin
      errors++;
      $display("FAIL pred_taken pc=%h got %b expected %b", lpc, pred_taken, exp_p);
    end
    @(posedge clk);
    mdl_update(v, upc, t, p);
    #1;
    checks++;
    if (mispredict !== mdl_mp) begin
      errors++;
      $display("FAIL mispredict got %b expected %b", mispredict, mdl_mp);
    end
    checks++;
    if (branch_count !== 32'(mdl_br)) begin
      errors++;
      $display("FAIL branch_count got %0d expected %0d", branch_count, mdl_br);
    end
    checks++;
    if (mispredict_count !== 32'(mdl_mis)) begin
      errors++;
      $display("FAIL mispredict_count got %0d expected %0d", mispredict_count, mdl_mis);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a <= 32'hFC; a += 4) begin
      pred_pc = 32'(a);
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep pc=%h got %b expected 0", pred_pc, pred_taken);
      end
    end
    checks++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts br=%0d mis=%0d mp=%b expected 0 0 0",
               branch_count, mispredict_count, mispredict);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_train_taken();
    do_reset();
    apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
`ifndef RISCVSINGLECYCLE_BP_GSHARE_EN
    pred_pc = 32'h40; #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL train_first pred_taken got %b expected 1", pred_taken);
    end
`endif
    apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
    checks++;
    if (branch_count !== 32'd2 || mispredict_count !== 32'd2 || mispredict !== 1'b1) begin
      errors++;
      $display("FAIL train_counts br=%0d mis=%0d mp=%b expected 2 2 1",
               branch_count, mispredict_count, mispredict);
    end
`ifndef RISCVSINGLECYCLE_BP_GSHARE_EN
    pred_pc = 32'h140; #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL alias_0x140 pred_taken got %b expected 1", pred_taken);
    end
`endif
    apply(1'b0, 32'h40, 1'b0, 1'b0, 32'h140);
  endtask

  task automatic test_saturate_down();
    do_reset();
    for (int k = 0; k < 5; k++) apply(1'b1, 32'h80, 1'b0, 1'($urandom_range(0, 1)), 32'h80);
    apply(1'b1, 32'h80, 1'b1, 1'b0, 32'h80);
`ifndef RISCVSINGLECYCLE_BP_GSHARE_EN
    pred_pc = 32'h80; #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL sat_down pred_taken got %b expected 0", pred_taken);
    end
`endif
    apply(1'b1, 32'h80, 1'b1, 1'b0, 32'h80);
  endtask

  task automatic test_same_cycle();
    do_reset();
    apply(1'b1, 32'h10, 1'b1, 1'b0, 32'h10);
    apply(1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
`ifndef RISCVSINGLECYCLE_BP_GSHARE_EN
    pred_pc = 32'h10; #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass_next pred_taken got %b expected 1", pred_taken);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    do_reset();
    pc = 32'(($urandom_range(0, 63)) << 2);
    for (int k = 0; k < 8; k++) apply(1'b1, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc);
    for (int k = 0; k < 4; k++) apply(1'b1, pc, 1'b1, 1'b0, pc);
    apply(1'b0, pc, 1'b0, 1'b0, pc);
  endtask

  task automatic test_random();
    logic [31:0] upc, lpc;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      upc = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8)
            | 32'($urandom_range(0, 3));
      lpc = ($urandom_range(0, 1) == 0) ? upc :
            ((32'($urandom_range(0, 63)) << 2) | (32'($urandom_range(0, 7)) << 12));
      apply(1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), lpc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 6; k++) apply(1'b1, 32'h20, 1'b1, 1'b0, 32'h20);
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b0; upd_pred = 1'b1; pred_pc = 32'h20;
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    checks++;
    if (pred_taken !== 1'b0 || mispredict !== 1'b0 || branch_count !== 32'd0 ||
        mispredict_count !== 32'd0) begin
      errors++;
      $display("FAIL async_clear pt=%b mp=%b br=%0d mis=%0d expected all 0",
               pred_taken, mispredict, branch_count, mispredict_count);
    end
    upd_taken = 1'b1; upd_pred = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (branch_count !== 32'd0 || mispredict !== 1'b0 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard br=%0d mp=%b pt=%b expected 0 0 0",
               branch_count, mispredict, pred_taken);
    end
    rst_n = 1'b1;
    apply(1'b1, 32'h20, 1'b1, 1'b0, 32'h20);
    checks++;
    if (branch_count !== 32'd1) begin
      errors++;
      $display("FAIL first_after_reset br=%0d expected 1", branch_count);
    end
    apply(1'b0, 32'h20, 1'b0, 1'b0, 32'h20);
  endtask

`ifdef RISCVSINGLECYCLE_BP_GSHARE_EN
  task automatic test_gshare();
    do_reset();
    apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
    apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
    apply(1'b1, 32'h40, 1'b0, 1'b0, 32'h40);
    // GHR is now 0b110, so this update trains index 16^6=22 and moves GHR to 13.
    apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
    // (0x6C>>2)^13 = 27^13 = 22
    pred_pc = 32'h6C; #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL gshare_idx22 pred_taken got %b expected 1", pred_taken);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_train_taken();
    test_saturate_down();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef RISCVSINGLECYCLE_BP_GSHARE_EN
    test_gshare();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscvsinglecycle_branch_predictor.md
RISCVSINGLECYCLE_BRANCH_PREDICTOR -- requirements
Module: RiscvSingleCycle_branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, SHALL set the number of 2-bit counters; it is a power of two, 4..1024.
REQ-002 Parameter GHR_BITS, default 6, SHALL set the global history width; it is at most log2(ENTRIES), and is used only under the Configuration macro.
REQ-003 Port list, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pred_pc  in  32  PC of the instruction being fetched.
- pred_taken  out  1  taken prediction for pred_pc.
- upd_valid  in  1  a resolved conditional branch is retiring this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  branch_taken result from the branch comparator.
- upd_pred  in  1  prediction that was issued for this branch.
- mispredict  out  1  registered mispredict flag.
- branch_count  out  32  number of resolved branches.
- mispredict_count  out  32  number of mispredicted branches.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-005 Base index SHALL be pc[log2(ENTRIES)+1:2]; PC bits [1:0] are ignored.
REQ-006 Each counter SHALL encode 0=strong-not-taken, 1=weak-not-taken, 2=weak-taken, 3=strong-taken.
REQ-007 pred_taken SHALL be bit 1 of the indexed counter, combinational from pred_pc, with zero-cycle latency.
REQ-008 On a rising edge with upd_valid=1, the counter at the update index SHALL move as follows:
- upd_taken=1: increment, saturating at 3.
- upd_taken=0: decrement, saturating at 0.
REQ-009 When upd_valid=0, no counter SHALL change.
REQ-010 When a lookup and an update hit the same index in the same cycle, pred_taken SHALL reflect the pre-update value; there is no bypass.
REQ-011 mispredict SHALL register (upd_valid & (upd_taken ^ upd_pred)) on every edge, so it is high for exactly one cycle after each mispredicted update.
REQ-012 branch_count SHALL increment by 1 on each edge with upd_valid=1.
REQ-013 mispredict_count SHALL increment by 1 on each edge where the mispredict condition is true.
REQ-014 Both counters SHALL saturate at 0xFFFF_FFFF and SHALL not wrap.
REQ-015 Updates to the same index on back-to-back cycles SHALL each take effect; none is lost.
REQ-016 upd_pred is taken as given; the block SHALL NOT recompute it from the table.

Reset
REQ-017 While rst_n=0, regardless of clk, the block SHALL hold:
- every table counter at 1 (weak-not-taken), so pred_taken=0;
- mispredict=0;
- branch_count=0 and mispredict_count=0;
- the GHR, when present, at 0.
REQ-018 Assertion of rst_n mid-operation SHALL discard any update presented in that cycle.
REQ-019 The first update SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-020 Macro RISCVSINGLECYCLE_BP_GSHARE_EN SHALL select gshare indexing.
REQ-021 With RISCVSINGLECYCLE_BP_GSHARE_EN defined:
- a GHR_BITS-wide history register is instantiated;
- both lookup and update indices are the base index XOR the zero-extended GHR;
- on each upd_valid edge, the GHR shifts left and upd_taken enters at bit 0;
- the update index uses the GHR value from before that shift, which equals the value used for the lookup in the single-cycle core.
REQ-022 With RISCVSINGLECYCLE_BP_GSHARE_EN undefined, no GHR SHALL exist and the index is the base index only.

Verification
REQ-023 After reset, sweep pred_pc over 0x0000_0000..0x0000_00FC in steps of 4 -> pred_taken=0 at every address; all count outputs are 0.
REQ-024 Apply two updates at upd_pc=0x40 with upd_taken=1 and upd_pred=0 ->
- pred_taken at 0x40 is 1 after the first update;
- mispredict is high for each of the 2 cycles following the updates;
- mispredict_count=2 and branch_count=2;
- pred_taken at 0x140 (same index with ENTRIES=64, non-gshare) is also 1.
REQ-025 Apply five not-taken updates at 0x80 -> the counter saturates at 0, then one taken update gives counter 1 and pred_taken=0.
REQ-026 Drive pred_pc=upd_pc=0x10 with upd_valid=1 and upd_taken=1 from reset -> pred_taken=0 in the update cycle and 1 in the next cycle.
REQ-027 Assert rst_n low asynchronously mid-cycle during a stream of updates -> all outputs clear immediately, without waiting for a clk edge.
REQ-028 With RISCVSINGLECYCLE_BP_GSHARE_EN defined, apply updates at 0x40 with outcome sequence T,T,N -> GHR=0b110, and the next lookup at 0x40 uses index 16^6=22.
